// File: rtl/fifo_out_stage_if.sv
// Handshake bundle between an upstream synchronous FIFO, the output stage
// and the downstream stream consumer. The master modport is the output
// stage itself; the slave modport is the environment around it.
interface fifo_out_stage_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    input  m_ready,
    output fifo_rd_en,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    output m_ready,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data
  );
endinterface

// File: rtl/fifo_out_stage.sv
// fifo_out_stage: turns a synchronous FIFO with one-cycle read latency into a
// valid/ready stream. A two-entry in-order buffer (head, skid) absorbs the
// read that is still in flight when the consumer stalls, so full throughput
// is kept without a combinational path from m_ready to the FIFO data.
//
// Optional feature: define FIFO_OUT_STAGE_CNT_EN to add the 16-bit out_count
// port, a wrapping count of words accepted by the consumer.
module fifo_out_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_out_stage_if.master bus
`ifdef FIFO_OUT_STAGE_CNT_EN
  ,
  output logic [15:0]      out_count
`endif
);

  logic [1:0]            occ;       // words held in head/skid: 0, 1 or 2
  logic                  inflight;  // a read was issued last cycle
  logic                  run;       // first edge after reset release seen
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] skid;
  logic                  pop;
  logic [1:0]            occ_next;  // occ + inflight - pop, never negative

  // Handshake decode: reads are only issued while the next occupancy leaves
  // room for the word that the read will return.
  always_comb begin
    // NOTE: every signal here is assigned unconditionally first, so the block
    // can never infer a latch.
    pop            = 1'b0;
    occ_next       = occ;
    bus.fifo_rd_en = 1'b0;
    pop            = (occ != 2'd0) && bus.m_ready;
    occ_next       = occ + {1'b0, inflight} - {1'b0, pop};
    bus.fifo_rd_en = run && !bus.fifo_empty && (occ_next <= 2'd1);
  end

  assign bus.m_valid = (occ != 2'd0);
  assign bus.m_data  = head;

  // Occupancy, outstanding-read flag and the post-reset read enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      run      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // flop samples the values from before the edge.
      occ      <= occ_next;
      inflight <= bus.fifo_rd_en;
      run      <= 1'b1;
    end
  end

  // Buffer entries: capture the returning FIFO word and shift skid to head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two storage entries are reset so m_data reads zero during
      // and right after reset; occ alone already marks them as empty.
      head <= '0;
      skid <= '0;
    end else if (pop) begin
      if (occ == 2'd2) begin
        head <= skid;
        if (inflight) begin
          skid <= bus.fifo_dout;
        end
      end else if (inflight) begin
        head <= bus.fifo_dout;
      end
    end else if (inflight) begin
      if (occ == 2'd0) begin
        head <= bus.fifo_dout;
      end else begin
        skid <= bus.fifo_dout;
      end
    end
  end

`ifdef FIFO_OUT_STAGE_CNT_EN
  // Count words accepted by the consumer, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count <= 16'd0;
    end else if (pop) begin
      out_count <= out_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fifo_out_stage.md
FIFO_OUT_STAGE -- requirements
Module: fifo_out_stage

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: width of FIFO read data and output stream data.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset; all state SHALL be clocked on the rising edge of clk.
REQ-003 Port: clk  input  1  system clock.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: fifo_empty  input  1  upstream synchronous FIFO empty flag.
REQ-006 Port: fifo_rd_en  output  1  read strobe to the upstream FIFO.
REQ-007 Port: fifo_dout  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
REQ-008 Port: m_valid  output  1  output word available.
REQ-009 Port: m_ready  input  1  downstream accepts the word.
REQ-010 Port: m_data  output  DATA_WIDTH  output word, head of the internal buffer.

Function
REQ-011 The block SHALL hold a 2-entry in-order buffer (head, skid), occupancy occ in {0,1,2}, plus a 1-bit inflight flag for a read issued last cycle.
REQ-012 Pop SHALL be pop = m_valid && m_ready; m_valid SHALL equal (occ != 0); m_data SHALL equal the head entry.
REQ-013 fifo_rd_en SHALL be !fifo_empty && (occ + inflight - pop) <= 1, combinational from registered state, fifo_empty and m_ready.
REQ-014 inflight SHALL be registered as the previous cycle's fifo_rd_en; when inflight=1, fifo_dout SHALL be captured at that clock edge.
REQ-015 Next occ SHALL be occ + inflight - pop; the invariant occ + inflight <= 2 SHALL always hold.
REQ-016 On simultaneous pop and capture: with occ=1, the captured word SHALL become head; with occ=2, the skid word SHALL move to head and the captured word to skid.
REQ-017 On capture without pop: occ=0 SHALL write head; occ=1 SHALL write skid.
REQ-018 On pop without capture with occ=2, the skid word SHALL move to head.
REQ-019 Word order SHALL be preserved; no word SHALL be dropped or duplicated.
REQ-020 First-word latency SHALL be 2 cycles: FIFO non-empty in cycle N with an empty stage gives fifo_rd_en in N and m_valid in N+2.
REQ-021 With FIFO non-empty and m_ready held high, throughput SHALL be one word per cycle after the first word.
REQ-022 With m_ready low, at most 2 words SHALL be read, then fifo_rd_en SHALL stay 0.
REQ-023 m_data and m_valid SHALL stay stable while m_valid=1 and m_ready=0.
REQ-024 fifo_rd_en SHALL never be asserted while fifo_empty=1.

Reset
REQ-025 While rst_n=0: occ=0, inflight=0, m_valid=0, m_data=0, fifo_rd_en=0, head and skid cleared.
REQ-026 Reset asserted mid-operation SHALL discard buffered and in-flight words; a FIFO word read in the cycle before reset SHALL be lost.
REQ-027 The first fifo_rd_en after reset release SHALL occur no earlier than the first clock edge with rst_n=1.

Configuration
REQ-028 When macro FIFO_OUT_STAGE_CNT_EN is defined, port out_count (output, 16 bits) SHALL exist and count pops, wrapping 0xFFFF to 0x0000, reset to 0.
REQ-029 Without FIFO_OUT_STAGE_CNT_EN, out_count and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 FIFO holds 0x11,0x22,0x33, m_ready=1 -> fifo_rd_en in cycles 0,1,2; m_data 0x11,0x22,0x33 in cycles 2,3,4; m_valid low in cycle 5.
REQ-031 FIFO holds 5 words, m_ready=0 for 6 cycles then 1 -> exactly 2 fifo_rd_en pulses while stalled; then all 5 words output in order, back-to-back.
REQ-032 m_ready toggled 1,0,1,0 against continuous FIFO data 0x01..0x10 -> output sequence 0x01..0x10 exact, m_data stable during every stall cycle.
REQ-033 fifo_empty=1 throughout, m_ready=1 -> fifo_rd_en and m_valid stay 0.
REQ-034 rst_n driven low with occ=2 and inflight=1 -> m_valid=0, m_data=0, fifo_rd_en=0 immediately; after release the next FIFO word 0xAA is the first output.
REQ-035 With FIFO_OUT_STAGE_CNT_EN, 65537 pops -> out_count=0x0001; without the macro, bench compiles with no out_count port.
